// File: rtl/sys_array_ctrl_if.sv
// Result-index handshake between the array sequencer and its consumer.
// The sequencer offers (row, col) with valid; the consumer accepts with ready.
interface sys_array_ctrl_if #(
  parameter int ROW_W = 2,
  parameter int COL_W = 2
);
  logic             rd_valid;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic             rd_ready;

  modport master (
    output rd_valid,
    output rd_row,
    output rd_col,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_row,
    input  rd_col,
    output rd_ready
  );
endinterface

// File: rtl/sys_array_ctrl.sv
// Run sequencer for the systolic array wrapper: load, compute, drain,
// then walk the result grid over a valid/ready handshake.
module sys_array_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ARRAY_W      = 4,
  parameter int ARRAY_L      = 4,
  parameter int INNER_DIM    = 4,
  parameter int CLOCK_DIVIDE = 2,
  parameter int LOAD_WAIT    = 2,
  parameter int ROW_W = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1,
  parameter int COL_W = (ARRAY_L > 1) ? $clog2(ARRAY_L) : 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic abort,
  output logic load_params,
  output logic start_comp,
  output logic busy,
  output logic done,
  sys_array_ctrl_if.master rd
);

  localparam int P      = CLOCK_DIVIDE;
  localparam int LW_CYC = LOAD_WAIT * P;
  localparam int DR_CYC =
    (ARRAY_W + ARRAY_L + INNER_DIM - 2) * P;
  localparam int MAX_A  = (P > LW_CYC) ? P : LW_CYC;
  localparam int CNT_MX = (MAX_A > DR_CYC) ? MAX_A : DR_CYC;
  localparam int CNT_W  = $clog2(CNT_MX + 1);

  localparam logic [CNT_W-1:0] P_LAST  = CNT_W'(P - 1);
  localparam logic [CNT_W-1:0] LW_LAST = CNT_W'(LW_CYC - 1);
  localparam logic [CNT_W-1:0] DR_LAST = CNT_W'(DR_CYC - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ARRAY_W - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ARRAY_L - 1);

  if (DATA_WIDTH < 1 || ARRAY_W < 1 || ARRAY_L < 1 ||
      INNER_DIM < 1 || CLOCK_DIVIDE < 1 ||
      LOAD_WAIT < 1) begin : g_bad_param
    $error("sys_array_ctrl: all parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LWAIT,
    S_COMP,
    S_DRAIN,
    S_READ,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lp_q, lp_d;
  logic             sc_q, sc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  logic xfer;
  logic last_col;
  logic last_idx;

  assign xfer     = valid_q & rd.rd_ready;
  assign last_col = (col_q == COL_LAST);
  assign last_idx = last_col & (row_q == ROW_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lp_d    = 1'b0;
    sc_d    = 1'b0;
    done_d  = 1'b0;
    valid_d = valid_q;
    row_d   = row_q;
    col_d   = col_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          lp_d    = 1'b1;
        end
      end
      S_LOAD: begin
        if (cnt_q == P_LAST) begin
          state_d = S_LWAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          lp_d  = 1'b1;
        end
      end
      S_LWAIT: begin
        if (cnt_q == LW_LAST) begin
          state_d = S_COMP;
          cnt_d   = '0;
          sc_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COMP: begin
        if (cnt_q == P_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          sc_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DR_LAST) begin
          state_d = S_READ;
          cnt_d   = '0;
          valid_d = 1'b1;
          row_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_READ: begin
        if (xfer) begin
          if (last_idx) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
          end else if (last_col) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        row_d   = '0;
        col_d   = '0;
      end
    endcase

    // Abort wins over everything except an already idle machine.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      lp_d    = 1'b0;
      sc_d    = 1'b0;
      done_d  = 1'b0;
      valid_d = 1'b0;
      row_d   = '0;
      col_d   = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lp_q    <= 1'b0;
      sc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lp_q    <= lp_d;
      sc_q    <= sc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign load_params = lp_q;
  assign start_comp  = sc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rd.rd_valid = valid_q;
  assign rd.rd_row   = row_q;
  assign rd.rd_col   = col_q;

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Bench for sys_array_ctrl: default 4x4x4/P=2 instance and a 2x3x5/P=1
// instance, checked cycle by cycle against a timeline/queue model.
module tb_sys_array_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int   sel = 0;
  logic start_x = 1'b0;
  logic abort_x = 1'b0;
  logic ready_x = 1'b0;

  int total = 0;
  int bad = 0;

  logic lp_a, sc_a, busy_a, done_a;
  logic lp_b, sc_b, busy_b, done_b;

  sys_array_ctrl_if #(.ROW_W(2), .COL_W(2)) rd_a ();
  sys_array_ctrl_if #(.ROW_W(1), .COL_W(2)) rd_b ();

  assign rd_a.rd_ready = (sel == 0) ? ready_x : 1'b0;
  assign rd_b.rd_ready = (sel == 1) ? ready_x : 1'b0;

  sys_array_ctrl u_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       ((sel == 0) ? start_x : 1'b0),
    .abort       ((sel == 0) ? abort_x : 1'b0),
    .load_params (lp_a),
    .start_comp  (sc_a),
    .busy        (busy_a),
    .done        (done_a),
    .rd          (rd_a.master)
  );

  sys_array_ctrl #(
    .ARRAY_W      (2),
    .ARRAY_L      (3),
    .INNER_DIM    (5),
    .CLOCK_DIVIDE (1),
    .LOAD_WAIT    (2)
  ) u_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       ((sel == 1) ? start_x : 1'b0),
    .abort       ((sel == 1) ? abort_x : 1'b0),
    .load_params (lp_b),
    .start_comp  (sc_b),
    .busy        (busy_b),
    .done        (done_b),
    .rd          (rd_b.master)
  );

  logic o_lp, o_sc, o_busy, o_valid, o_done;
  int   o_row, o_col;
  assign o_lp    = sel ? lp_b : lp_a;
  assign o_sc    = sel ? sc_b : sc_a;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_done  = sel ? done_b : done_a;
  assign o_valid = sel ? rd_b.rd_valid : rd_a.rd_valid;
  assign o_row   = sel ? int'(rd_b.rd_row) : int'(rd_a.rd_row);
  assign o_col   = sel ? int'(rd_b.rd_col) : int'(rd_a.rd_col);

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int pins();
    return int'({o_lp, o_sc, o_busy, o_valid, o_done});
  endfunction

  // One run from a start request; expectations come from the phase
  // lengths (P, LOAD_WAIT*P, (W+L+K-2)*P) and a queue of grid indices.
  task automatic run(input int s, input int rmode, input int hold_from,
                     input int ab_r, input int ab_c,
                     output int n_lp, output int sc_first,
                     output int v_first, output int n_xfer,
                     output int n_done);
    int p, lw, w, l, kd, d, r0, k, post;
    int qr[$];
    int qc[$];
    bit fin, aborted, e_lp, e_sc, e_busy, e_v, e_done;
    p  = s ? 1 : 2;
    lw = 2;
    w  = s ? 2 : 4;
    l  = s ? 3 : 4;
    kd = s ? 5 : 4;
    d  = (w + l + kd - 2) * p;
    r0 = 2 * p + lw * p + d;
    for (int r = 0; r < w; r++)
      for (int c = 0; c < l; c++) begin
        qr.push_back(r);
        qc.push_back(c);
      end
    n_lp = 0; sc_first = 0; v_first = 0; n_xfer = 0; n_done = 0;
    sel = s;
    start_x = 1'b1;
    abort_x = 1'b0;
    k = 0; post = 0; fin = 0; aborted = 0;
    while (!fin && k < 1000) begin
      @(posedge clk);
      #1;
      k++;
      e_lp = 0; e_sc = 0; e_busy = 1; e_v = 0; e_done = 0;
      if (aborted) begin
        e_busy = 0;
        post++;
        fin = (post >= 2);
      end else if (k <= r0) begin
        e_lp = (k <= p);
        e_sc = (k > p + lw * p) && (k <= 2 * p + lw * p);
      end else if (qr.size() > 0) begin
        e_v = 1;
      end else begin
        post++;
        e_done = (post == 1);
        e_busy = (post == 1);
        fin = (post >= 2);
      end
      check("outputs{lp,sc,busy,valid,done}", pins(),
            int'({e_lp, e_sc, e_busy, e_v, e_done}));
      if (e_v) begin
        check("rd_row", o_row, qr[0]);
        check("rd_col", o_col, qc[0]);
      end
      n_lp += int'(o_lp);
      n_done += int'(o_done);
      if (o_sc && sc_first == 0) sc_first = k;
      if (o_valid && v_first == 0) v_first = k;
      start_x = (hold_from > 0 && k >= hold_from);
      case (rmode)
        0: ready_x = 1'b1;
        1: ready_x = (k % 2 == 0);
        default: ready_x = 1'($urandom_range(0, 1));
      endcase
      abort_x = 1'b0;
      if (e_v && qr[0] == ab_r && qc[0] == ab_c) begin
        abort_x = 1'b1;
        ready_x = 1'b0;
        aborted = 1;
      end
      if (o_valid && ready_x) n_xfer++;
      if (e_v && ready_x) begin
        void'(qr.pop_front());
        void'(qc.pop_front());
      end
    end
    abort_x = 1'b0;
    if (!fin) check("run_timeout", 0, 1);
  endtask

  typedef struct {
    int sel;
    int rmode;
    int exp_lp;
    int exp_sc;
    int exp_v;
    int exp_x;
    int exp_done;
  } vec_t;

  vec_t tbl[5];
  int n_lp, sc_first, v_first, n_xfer, n_done;

  initial begin
    tbl[0] = '{0, 0, 2, 7, 29, 16, 1};
    tbl[1] = '{0, 1, 2, 7, 29, 16, 1};
    tbl[2] = '{0, 2, 2, 7, 29, 16, 1};
    tbl[3] = '{1, 0, 1, 4, 13, 6, 1};
    tbl[4] = '{1, 2, 1, 4, 13, 6, 1};

    #1;
    check("reset_a", int'({lp_a, sc_a, busy_a, rd_a.rd_valid, done_a}), 0);
    check("reset_b", int'({lp_b, sc_b, busy_b, rd_b.rd_valid, done_b}), 0);
    #20 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      run(tbl[i].sel, tbl[i].rmode, 0, -1, -1,
          n_lp, sc_first, v_first, n_xfer, n_done);
      check("tbl_lp_cycles", n_lp, tbl[i].exp_lp);
      check("tbl_sc_first", sc_first, tbl[i].exp_sc);
      check("tbl_valid_first", v_first, tbl[i].exp_v);
      check("tbl_transfers", n_xfer, tbl[i].exp_x);
      check("tbl_done", n_done, tbl[i].exp_done);
    end

    // start raised in DRAIN and held: ignored until IDLE, then a new run.
    run(0, 0, 15, -1, -1, n_lp, sc_first, v_first, n_xfer, n_done);
    check("hold_run1_xfer", n_xfer, 16);
    check("hold_run1_done", n_done, 1);
    run(0, 1, 0, -1, -1, n_lp, sc_first, v_first, n_xfer, n_done);
    check("hold_run2_sc", sc_first, 7);
    check("hold_run2_valid", v_first, 29);
    check("hold_run2_xfer", n_xfer, 16);

    // abort while (1,2) is offered
    run(0, 0, 0, 1, 2, n_lp, sc_first, v_first, n_xfer, n_done);
    check("abort_xfer", n_xfer, 6);
    check("abort_done", n_done, 0);
    run(0, 0, 0, -1, -1, n_lp, sc_first, v_first, n_xfer, n_done);
    check("post_abort_xfer", n_xfer, 16);
    check("post_abort_done", n_done, 1);

    // asynchronous reset in the middle of LOAD
    sel = 0;
    start_x = 1'b1;
    @(posedge clk);
    #1 start_x = 1'b0;
    check("rst_pre_lp", int'(lp_a), 1);
    #3 reset_n = 1'b0;
    #1;
    check("rst_async", pins(), 0);
    repeat (2) begin
      @(posedge clk);
      #1 check("rst_held", pins(), 0);
    end
    reset_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1 check("rst_after", pins(), 0);
    end

    run(1, 1, 0, -1, -1, n_lp, sc_first, v_first, n_xfer, n_done);
    check("b_toggle_xfer", n_xfer, 6);
    check("b_toggle_done", n_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sys_array_ctrl.md
Name: sys_array_ctrl

Overview:
Sequencer for the systolic array wrapper. On a single run request it pulses the array's parameter-load and compute-start inputs, stretching each pulse to the wrapper's divided clock. It then waits out the systolic fill/drain latency and walks the ARRAY_W x ARRAY_L result grid with a valid/ready handshake, so a host or display mux can collect every result. It sits between the host/top-level control and sys_array_wrapper.

Parameters:
DATA_WIDTH, 8, element width (passed through for consistency; no arithmetic on data)
ARRAY_W, 4, array rows (i)
ARRAY_L, 4, array columns (j)
INNER_DIM, 4, shared matrix dimension K streamed through the array, >=1
CLOCK_DIVIDE, 2, ratio of clk to array clock; every array-facing pulse lasts exactly CLOCK_DIVIDE clk cycles, >=1
LOAD_WAIT, 2, array-clock cycles to wait after load_params before start_comp, >=1

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  run request, sampled on clk; accepted only in IDLE
abort  in  1  synchronous abort; returns FSM to IDLE from any state
load_params  out  1  to wrapper load_params, registered
start_comp  out  1  to wrapper start_comp, registered
busy  out  1  high whenever state != IDLE
rd_valid  out  1  result index valid
rd_row  out  $clog2(ARRAY_W) (min 1)  row of offered result
rd_col  out  $clog2(ARRAY_L) (min 1)  column of offered result
rd_ready  in  1  consumer accepts current index
done  out  1  one-cycle pulse after last result accepted

Behaviour:
- Reset (async, reset_n=0): state=IDLE, all outputs 0, counters 0. Deassertion takes effect on the next clk edge; reset mid-run abandons the run with no done.
- All outputs registered; one free-running cycle counter cnt reused per state.
- Let P=CLOCK_DIVIDE, D=(ARRAY_W+ARRAY_L+INNER_DIM-2)*P.
- IDLE: start=1 at edge t0 -> LOAD; busy=1 from t0.
- LOAD: load_params=1 for exactly P cycles (the cycles after edges t0..t0+P-1), then -> LWAIT.
- LWAIT: all array pulses low for LOAD_WAIT*P cycles -> COMP.
- COMP: start_comp=1 for exactly P cycles -> DRAIN.
- DRAIN: D cycles with pulses low -> READ, with rd_row=0, rd_col=0, rd_valid=1.
- READ: transfer occurs on an edge with rd_valid&rd_ready. Index advances column-major-inner (col increments; at col=ARRAY_L-1, col wraps to 0 and row increments). rd_row/rd_col are held stable while rd_valid&!rd_ready. After the transfer of (ARRAY_W-1, ARRAY_L-1) -> DONE; rd_valid=0.
- DONE: done=1 for one cycle; busy stays 1 that cycle -> IDLE. The start check is made in IDLE only, so back-to-back runs need start high after done.
- start outside IDLE is ignored and not queued.
- abort=1 (any non-IDLE state) -> IDLE next edge; load_params, start_comp, rd_valid, busy cleared; no done. abort beats start in the same cycle. abort in IDLE has no effect.
- load_params and start_comp are never high simultaneously, and are never high outside LOAD/COMP.
- Defaults timeline (start at t0): load_params cycles 1-2, start_comp cycles 7-8, first rd_valid cycle 29.

Test Plan:
- Defaults, single start pulse, rd_ready tied 1: load_params high 2 cycles, start_comp high 2 cycles starting 4 cycles after load drop, rd_valid at t0+29. 16 consecutive indices (0,0),(0,1)…(3,3). done one cycle after the last transfer, then busy=0.
- Backpressure: rd_ready toggles 1/0 every cycle: each index is held while not ready, no index is skipped or repeated, 16 transfers total, done once.
- start reasserted during DRAIN, then held high through DONE: the mid-run start has no effect. A second run begins only once IDLE is reached and start is sampled, with an identical pulse timeline.
- abort during READ at index (1,2): next cycle rd_valid=0, busy=0, no done. A new start gives a full 16-index run from (0,0).
- reset_n dropped asynchronously mid-LOAD: outputs go 0 immediately without a clk edge; after release, IDLE with no spurious pulses.
- CLOCK_DIVIDE=1, ARRAY_W=2, ARRAY_L=3, INNER_DIM=5: load 1 cycle, LWAIT 2, start_comp 1, drain 8. 6 indices, with rd_row width 1 and rd_col width 2.
